// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment display controller: one value register shown in hex or
// decimal, with leading-zero suppression, per-digit blanking and blinking.
module hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 4 * NUM_DIGITS,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [1:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy
);
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV);
  localparam logic [DATA_W:0] DEC_LIMIT = (DATA_W + 1)'(10 ** NUM_DIGITS);
  localparam logic [7*NUM_DIGITS-1:0] RESET_HEX = {NUM_DIGITS{ACTIVE_LOW ? 7'h40 : 7'h3F}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0]     value_q, bin_q;
  logic [2:0]            ctrl_q;
  logic [NUM_DIGITS-1:0] blank_q, lz_off;
  logic [BCD_W-1:0]      bcd_q, bcd_adj, digit_q;
  logic [CNT_W-1:0]      shift_cnt_q;
  logic [BLK_W-1:0]      blink_cnt_q;
  logic                  overflow_q, ovf_pend_q, phase_q;
  logic                  wr_value, wr_ctrl, wr_blank, start, abort, commit, all_zero;
  logic [6:0]            seg;
  logic [7*NUM_DIGITS-1:0] hex_d;
  logic                  unused_wdata;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  assign wr_value     = avs_write && (avs_address == 2'd0);
  assign wr_ctrl      = avs_write && (avs_address == 2'd1);
  assign wr_blank     = avs_write && (avs_address == 2'd2);
  assign start        = (wr_value && ctrl_q[0]) || (wr_ctrl && avs_writedata[0]);
  assign abort        = !ctrl_q[0] || (wr_ctrl && !avs_writedata[0]);
  // A restart or mode change in DONE discards the finished result.
  assign commit       = (state_q == S_DONE) && !start && !abort;
  assign busy         = (state_q != S_IDLE);
  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      value_q      <= '0;
      ctrl_q       <= '0;
      blank_q      <= '0;
      avs_readdata <= '0;
    end else begin
      if (wr_value) value_q <= avs_writedata[DATA_W-1:0];
      if (wr_ctrl)  ctrl_q  <= avs_writedata[2:0];
      if (wr_blank) blank_q <= avs_writedata[NUM_DIGITS-1:0];
      if (avs_read) begin
        case (avs_address)
          2'd0:    avs_readdata <= 32'(value_q);
          2'd1:    avs_readdata <= {29'd0, ctrl_q};
          2'd2:    avs_readdata <= 32'(blank_q);
          default: avs_readdata <= {30'd0, overflow_q, busy};
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LOAD;
    end else if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_LOAD:  state_d = S_SHIFT;
        S_SHIFT: if (shift_cnt_q == CNT_W'(DATA_W - 1)) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Double-dabble: add 3 to every BCD digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      ovf_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          bin_q       <= value_q;
          bcd_q       <= '0;
          shift_cnt_q <= '0;
          ovf_pend_q  <= ({1'b0, value_q} >= DEC_LIMIT);
        end
        S_SHIFT: begin
          bcd_q       <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
          bin_q       <= {bin_q[DATA_W-2:0], 1'b0};
          shift_cnt_q <= shift_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      digit_q     <= '0;
      overflow_q  <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hex_out     <= RESET_HEX;
    end else begin
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      if (!ctrl_q[0]) begin
        digit_q    <= value_q[BCD_W-1:0];
        overflow_q <= 1'b0;
      end else if (commit) begin
        digit_q    <= bcd_q;
        overflow_q <= ovf_pend_q;
      end
      hex_out <= hex_d;
    end
  end

  // On overflow the value is nonzero above every digit, so nothing counts as a leading zero.
  always_comb begin
    lz_off   = '0;
    all_zero = !overflow_q;
    for (int unsigned k = 0; k + 1 < NUM_DIGITS; k++) begin
      all_zero = all_zero && (digit_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      lz_off[NUM_DIGITS-1-k] = all_zero;
    end
    hex_d = '0;
    seg   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      seg = glyph(digit_q[4*i +: 4]);
      if ((ctrl_q[2] && phase_q) || blank_q[i] || (ctrl_q[1] && lz_off[i])) seg = '0;
      else if (overflow_q) seg = 7'h40;
      hex_d[7*i +: 7] = ACTIVE_LOW ? ~seg : seg;
    end
  end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: register table, hand-written corner
// sequences and randomized values against an arithmetic display model.
module tb_hex_display_ctrl;
  localparam int unsigned ND = 6;
  localparam int unsigned DW = 24;
  localparam int unsigned HW = 7 * ND;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    avs_address;
  logic          avs_write, avs_read;
  logic [31:0]   avs_writedata, avs_readdata;
  logic [HW-1:0] hex_out;
  logic          busy;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .hex_out(hex_out), .busy(busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int edges;
  always @(posedge clk) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct { logic [1:0] addr; logic [31:0] wdata; logic [31:0] exp; } reg_vec_t;
  reg_vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected active-low segments, derived from the value by plain arithmetic.
  function automatic logic [HW-1:0] model_hex(input longint unsigned v, input bit dec,
                                              input bit lz, input logic [ND-1:0] blank,
                                              input bit dark);
    longint unsigned p;
    longint unsigned d [ND];
    int top;
    bit ovf;
    logic [6:0] s;
    logic [HW-1:0] r;
    p = 1; top = 0; r = '0;
    for (int i = 0; i < ND; i++) begin
      d[i] = dec ? (v / p) % 10 : (v >> (4 * i)) & 64'hF;
      p = p * 10;
    end
    ovf = dec && (v >= p);
    for (int i = 0; i < ND; i++) if (d[i] != 0) top = i;
    if (ovf) top = ND - 1;
    for (int i = 0; i < ND; i++) begin
      s = GLYPH[d[i][3:0]];
      if (dark || blank[i] || (lz && i > top)) s = 7'h00;
      else if (ovf) s = 7'h40;
      r[7*i +: 7] = ~s;
    end
    return r;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0]     rd;
    int              cyc, seen;
    longint unsigned v;
    bit              dec, lz, ph, ovf;
    logic [ND-1:0]   bl;

    vecs[0] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{2'd0, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    vecs[2] = '{2'd0, 32'h0012_3456, 32'h0012_3456};
    vecs[3] = '{2'd2, 32'hFFFF_FFC5, 32'h0000_0005};
    vecs[4] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{2'd1, 32'hFFFF_FFFA, 32'h0000_0002};
    vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{2'd1, 32'h0000_0000, 32'h0000_0000};

    rst_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_hex", hex_out, {ND{7'h40}});
    check("rst_busy", busy, 1'b0);
    check("rst_readdata", avs_readdata, 32'h0);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check("rst_reg", rd, 32'h0);
    end

    // Hex mode: digit latch one edge after the write, output register one more.
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h00ABCD);
    @(negedge clk);
    check("hex_latency_old", hex_out, {ND{7'h40}});
    @(negedge clk);
    check("hex_abcd", hex_out, model_hex(64'hABCD, 1'b0, 1'b0, '0, 1'b0));
    check("hex_digit0", hex_out[6:0], 7'b0100001);

    for (int i = 0; i < 8; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check("reg_table", rd, vecs[i].exp);
    end

    bus_write(2'd0, 32'h111);
    @(negedge clk);
    avs_address = 2'd0; avs_writedata = 32'h222; avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0;
    check("rw_same_cycle_old", avs_readdata, 32'h111);
    bus_read(2'd0, rd);
    check("rw_new_value", rd, 32'h222);

    // Decimal with lz_suppress: busy length and no early update.
    bus_write(2'd1, 32'd3);
    wait_idle(cyc);
    bus_write(2'd0, 32'd123456);
    wait_idle(cyc);
    check("busy_cycles", cyc, 26);
    check("dec_old_held", hex_out, model_hex(546, 1'b1, 1'b1, '0, 1'b0));
    @(negedge clk);
    check("dec_123456", hex_out, model_hex(123456, 1'b1, 1'b1, '0, 1'b0));
    bus_write(2'd0, 32'd42);
    wait_idle(cyc);
    repeat (2) @(negedge clk);
    check("dec_42_lz", hex_out, model_hex(42, 1'b1, 1'b1, '0, 1'b0));

    bus_write(2'd1, 32'd1);
    wait_idle(cyc);
    bus_write(2'd0, 32'd999999);
    repeat (2) @(negedge clk);
    bus_write(2'd0, 32'd1000000);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hex_out == model_hex(999999, 1'b1, 1'b0, '0, 1'b0)) seen++;
    end
    check("restart_no_999999", seen, 0);
    check("ovf_dash", hex_out, {ND{7'h3F}});
    bus_read(2'd3, rd);
    check("status_ovf", rd, 32'h2);
    bus_write(2'd0, 32'd999999);
    wait_idle(cyc);
    repeat (2) @(negedge clk);
    check("dec_999999", hex_out, model_hex(999999, 1'b1, 1'b0, '0, 1'b0));
    bus_read(2'd3, rd);
    check("status_no_ovf", rd, 32'h0);

    // Blink with digit 0 blanked; hex_out lags the blink phase by one edge.
    bus_write(2'd2, 32'h01);
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'd123456);
    wait_idle(cyc);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      ph = (((edges - 1) / 4) % 2) == 1;
      check("blink", hex_out, model_hex(123456, 1'b1, 1'b0, 6'h01, ph));
    end
    bus_write(2'd2, 32'h0);

    // Reset in the middle of the shift phase.
    bus_write(2'd1, 32'd1);
    wait_idle(cyc);
    bus_write(2'd0, 32'd123456);
    repeat (10) @(negedge clk);
    check("busy_mid_shift", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_abort_busy", busy, 1'b0);
    check("rst_abort_hex", hex_out, {ND{7'h40}});
    rst_n = 1'b1;
    bus_read(2'd3, rd);
    check("rst_abort_status", rd, 32'h0);
    bus_write(2'd1, 32'd1);
    wait_idle(cyc);
    bus_write(2'd0, 32'd7);
    wait_idle(cyc);
    check("busy_cycles_7", cyc, 26);
    repeat (2) @(negedge clk);
    check("dec_7", hex_out, model_hex(7, 1'b1, 1'b0, '0, 1'b0));

    for (int it = 0; it < 40; it++) begin
      dec = 1'($urandom_range(0, 1));
      lz  = 1'($urandom_range(0, 1));
      bl  = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
      v   = longint'($urandom() & 32'hFF_FFFF) >> $urandom_range(0, 23);
      bus_write(2'd2, 32'(bl));
      bus_write(2'd1, {30'd0, lz, dec});
      bus_write(2'd0, 32'(v));
      wait_idle(cyc);
      repeat (2) @(negedge clk);
      check("rand_hex", hex_out, model_hex(v, dec, lz, bl, 1'b0));
      ovf = dec && (v >= 64'd1000000);
      bus_read(2'd3, rd);
      check("rand_status", rd, {30'd0, ovf, 1'b0});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
